// File: rtl/sync_pkg.sv
// Shared constants and helpers for the sync word detector.
package sync_pkg;

  localparam int unsigned SYNC_LEN_DEF  = 8;
  localparam logic [31:0] SYNC_WORD_DEF = 32'h0000_00A5;
  localparam int unsigned HIT_CNT_W     = 16;
  localparam int unsigned ERR_W_DEF     = $clog2(SYNC_LEN_DEF + 1);

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/sync_hamming.sv
// Combinational Hamming distance of a SYNC_LEN-bit word against a fixed pattern.
module sync_hamming
  import sync_pkg::*;
#(
  parameter int unsigned         SYNC_LEN = SYNC_LEN_DEF,
  parameter logic [SYNC_LEN-1:0] PATTERN  = SYNC_WORD_DEF[SYNC_LEN-1:0],
  parameter int unsigned         ERR_W    = $clog2(SYNC_LEN + 1)
) (
  input  logic [SYNC_LEN-1:0] i_word,
  output logic [ERR_W-1:0]    o_dist
);

  logic [31:0] w_diff;

  assign w_diff = 32'(i_word ^ PATTERN);
  assign o_dist = ERR_W'(popcount(w_diff));

endmodule

// File: rtl/sync_word_detector.sv
// Serial sync word detector with error tolerance and hit hold-off.
// Define SYNC_WORD_DETECTOR_INVERT_EN to also match the inverted pattern (adds sync_inv).
module sync_word_detector
  import sync_pkg::*;
#(
  parameter int unsigned         SYNC_LEN  = SYNC_LEN_DEF,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD = SYNC_WORD_DEF[SYNC_LEN-1:0],
  parameter int unsigned         MAX_ERR   = 0,
  parameter int unsigned         HOLDOFF   = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           bit_in,
  input  logic                           bit_valid,
  input  logic                           flush,
  output logic                           syncFlag,
  output logic [$clog2(SYNC_LEN+1)-1:0]  match_err,
  output logic [HIT_CNT_W-1:0]           hit_cnt
`ifdef SYNC_WORD_DETECTOR_INVERT_EN
  ,
  output logic                           sync_inv
`endif
);

  localparam int unsigned ERR_W = $clog2(SYNC_LEN + 1);
  localparam int unsigned HO_W  = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  // Only SYNC_LEN-1 bits of history are kept; the incoming bit completes the window.
  logic [SYNC_LEN-2:0] r_hist;
  logic [ERR_W-1:0]    r_fill;
  logic [HO_W-1:0]     r_holdoff;

  logic [SYNC_LEN-1:0] w_next_sr;
  logic [ERR_W-1:0]    w_dist_true;
  logic [ERR_W-1:0]    w_err;
  logic                w_fill_ok;
  logic                w_hit_true;
  logic                w_sel_inv;
  logic                w_hit;

  assign w_next_sr  = {r_hist, bit_in};
  assign w_fill_ok  = (r_fill >= ERR_W'(SYNC_LEN - 1));
  assign w_hit_true = (w_dist_true <= ERR_W'(MAX_ERR));

  sync_hamming #(
    .SYNC_LEN (SYNC_LEN),
    .PATTERN  (SYNC_WORD),
    .ERR_W    (ERR_W)
  ) u_ham_true (
    .i_word (w_next_sr),
    .o_dist (w_dist_true)
  );

`ifdef SYNC_WORD_DETECTOR_INVERT_EN
  logic [ERR_W-1:0] w_dist_inv;
  logic             w_hit_inv;

  sync_hamming #(
    .SYNC_LEN (SYNC_LEN),
    .PATTERN  (~SYNC_WORD),
    .ERR_W    (ERR_W)
  ) u_ham_inv (
    .i_word (w_next_sr),
    .o_dist (w_dist_inv)
  );

  assign w_hit_inv = (w_dist_inv <= ERR_W'(MAX_ERR));
  // True polarity wins when both qualify.
  assign w_sel_inv = !w_hit_true && w_hit_inv;
  assign w_err     = w_sel_inv ? w_dist_inv : w_dist_true;
`else
  assign w_sel_inv = 1'b0;
  assign w_err     = w_dist_true;
`endif

  assign w_hit = bit_valid && !flush && w_fill_ok && (r_holdoff == '0) &&
                 (w_hit_true || w_sel_inv);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hist    <= '0;
      r_fill    <= '0;
      r_holdoff <= '0;
      syncFlag  <= 1'b0;
      match_err <= '0;
      hit_cnt   <= '0;
`ifdef SYNC_WORD_DETECTOR_INVERT_EN
      sync_inv  <= 1'b0;
`endif
    end else begin
      syncFlag  <= w_hit;
      match_err <= w_hit ? w_err : '0;
`ifdef SYNC_WORD_DETECTOR_INVERT_EN
      sync_inv  <= w_hit && w_sel_inv;
`endif
      if (w_hit && (hit_cnt != '1)) begin
        hit_cnt <= hit_cnt + HIT_CNT_W'(1);
      end
      if (flush) begin
        r_hist    <= '0;
        r_fill    <= '0;
        r_holdoff <= '0;
      end else if (bit_valid) begin
        r_hist <= w_next_sr[SYNC_LEN-2:0];
        if (r_fill != ERR_W'(SYNC_LEN)) begin
          r_fill <= r_fill + ERR_W'(1);
        end
        if (w_hit) begin
          r_holdoff <= HO_W'(HOLDOFF);
        end else if (r_holdoff != '0) begin
          r_holdoff <= r_holdoff - HO_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sync_word_detector.sv
// Scoreboard bench: three detector variants (exact, MAX_ERR=1, HOLDOFF=8) share one bit stream.
module tb_sync_word_detector;

`ifdef SYNC_WORD_DETECTOR_INVERT_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic bit_in = 1'b0;
  logic bit_valid = 1'b0;
  logic flush = 1'b0;

  logic [2:0]  flag;
  logic [2:0]  inv;
  logic [3:0]  err [3];
  logic [15:0] hc  [3];

  always #5 clk = ~clk;

  sync_word_detector #(.SYNC_LEN(8), .SYNC_WORD(8'hA5), .MAX_ERR(0), .HOLDOFF(0)) dut0 (
    .clk (clk), .reset (reset), .bit_in (bit_in), .bit_valid (bit_valid), .flush (flush),
    .syncFlag (flag[0]), .match_err (err[0]), .hit_cnt (hc[0])
`ifdef SYNC_WORD_DETECTOR_INVERT_EN
    , .sync_inv (inv[0])
`endif
  );

  sync_word_detector #(.SYNC_LEN(8), .SYNC_WORD(8'hA5), .MAX_ERR(1), .HOLDOFF(0)) dut1 (
    .clk (clk), .reset (reset), .bit_in (bit_in), .bit_valid (bit_valid), .flush (flush),
    .syncFlag (flag[1]), .match_err (err[1]), .hit_cnt (hc[1])
`ifdef SYNC_WORD_DETECTOR_INVERT_EN
    , .sync_inv (inv[1])
`endif
  );

  sync_word_detector #(.SYNC_LEN(8), .SYNC_WORD(8'hA5), .MAX_ERR(0), .HOLDOFF(8)) dut2 (
    .clk (clk), .reset (reset), .bit_in (bit_in), .bit_valid (bit_valid), .flush (flush),
    .syncFlag (flag[2]), .match_err (err[2]), .hit_cnt (hc[2])
`ifdef SYNC_WORD_DETECTOR_INVERT_EN
    , .sync_inv (inv[2])
`endif
  );

`ifndef SYNC_WORD_DETECTOR_INVERT_EN
  assign inv = 3'b000;
`endif

  typedef struct packed {
    logic [2:0]       flag;
    logic [2:0]       inv;
    logic [2:0][3:0]  err;
    logic [2:0][15:0] hc;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  int unsigned m_me [3] = '{0, 1, 0};
  int unsigned m_ld [3] = '{0, 0, 8};
  logic [7:0]  m_sr [3];
  int unsigned m_fill [3];
  int unsigned m_ho [3];
  int unsigned m_hc [3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned pc8(input logic [7:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 8; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_sr[k] = 8'h00; m_fill[k] = 0; m_ho[k] = 0; m_hc[k] = 0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_flag%0d", tag, k), 32'(flag[k]), 32'd0);
      check($sformatf("%s_err%0d", tag, k), 32'(err[k]), 32'd0);
      check($sformatf("%s_hc%0d", tag, k), 32'(hc[k]), 32'd0);
      if (INV) check($sformatf("%s_inv%0d", tag, k), 32'(inv[k]), 32'd0);
    end
  endtask

  // Drive one cycle, predict every variant's registered outputs, then compare after the edge.
  task automatic step(input logic v, input logic b, input logic f);
    exp_t e;
    logic [7:0] nsr;
    int unsigned dt, di;
    bit hit, use_inv;
    e = '0;
    for (int k = 0; k < 3; k++) begin
      if (f) begin
        m_sr[k] = 8'h00; m_fill[k] = 0; m_ho[k] = 0;
      end else if (v) begin
        nsr = {m_sr[k][6:0], b};
        dt  = pc8(nsr ^ 8'hA5);
        di  = pc8(nsr ^ 8'h5A);
        if (m_fill[k] < 8) m_fill[k]++;
        hit = (m_fill[k] == 8) && (m_ho[k] == 0) && ((dt <= m_me[k]) || (INV && di <= m_me[k]));
        if (hit) begin
          use_inv    = !(dt <= m_me[k]);
          e.flag[k]  = 1'b1;
          e.inv[k]   = use_inv;
          e.err[k]   = use_inv ? 4'(di) : 4'(dt);
          if (m_hc[k] < 65535) m_hc[k]++;
          m_ho[k] = m_ld[k];
        end else if (m_ho[k] > 0) begin
          m_ho[k]--;
        end
        m_sr[k] = nsr;
      end
      e.hc[k] = 16'(m_hc[k]);
    end
    sb_q.push_back(e);
    bit_valid = v; bit_in = b; flush = f;
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("flag%0d", k), 32'(flag[k]), 32'(e.flag[k]));
      check($sformatf("err%0d", k), 32'(err[k]), 32'(e.err[k]));
      check($sformatf("hc%0d", k), 32'(hc[k]), 32'(e.hc[k]));
      if (INV) check($sformatf("inv%0d", k), 32'(inv[k]), 32'(e.inv[k]));
    end
  endtask

  task automatic send_bits(input logic [7:0] w, input int n);
    for (int i = 7; i > 7 - n; i--) step(1'b1, w[i], 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] w);
    send_bits(w, 8);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] low_half;
    model_reset();
    #2;
    check_all_zero("rst");
    @(negedge clk);
    reset = 1'b0;

    send_byte(8'hA5);                 // all three hit, err 0
    idle(2);
    send_byte(8'hA4);                 // 1 error: only MAX_ERR=1 variant
    send_byte(8'hA6);                 // 2 errors: nobody
    idle(1);
    send_bits(8'hA5, 7);
    idle(4);
    step(1'b1, 1'b1, 1'b0);           // last bit of A5 after idle gap
    send_byte(8'h00);
    send_byte(8'hA5);                 // hold-off: A5 A5 00 A5
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'hA5);
    step(1'b1, 1'b1, 1'b0);           // flag stays one cycle with bit_valid high

    send_bits(8'hA5, 4);
    step(1'b1, 1'b0, 1'b1);           // flush with bit_valid: bit discarded
    low_half = 8'h50;
    send_bits(low_half, 4);
    send_byte(8'hA5);

    send_byte(8'h5A);                 // inverted pattern
    idle(1);

    send_byte(8'hA5);
    reset = 1'b1;                     // async reset while syncFlag is high
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    send_bits(low_half, 4);           // partial word after reset must not hit
    send_byte(8'hA5);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
